// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM slot arbiter.
package sdram_arb_pkg;

  localparam int NPORT             = 3;
  localparam int PORT_LOADER       = 0;
  localparam int PORT_P1           = 1;
  localparam int PORT_P2           = 2;
  localparam int SLOT_LEN_DEF      = 16;
  localparam int CAPTURE_PHASE_DEF = 12;

  // Byte address as {bank[1:0], addr[22:0]}
  typedef logic [24:0] addr_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// Three-way priority encoder: the loader always wins, and ports 1/2 alternate via rr.
module sdram_arb_prio
  import sdram_arb_pkg::*;
(
  input  logic [NPORT-1:0] pend,
  input  logic             rr,    // 0: port 1 favoured, 1: port 2 favoured
  output logic [NPORT-1:0] gnt
);

  // One-hot winner among the pending ports
  always_comb begin
    gnt = '0;
    if (pend[PORT_LOADER])
      gnt[PORT_LOADER] = 1'b1;
    else if (pend[PORT_P1] && pend[PORT_P2])
      gnt[rr ? PORT_P2 : PORT_P1] = 1'b1;
    else if (pend[PORT_P1])
      gnt[PORT_P1] = 1'b1;
    else if (pend[PORT_P2])
      gnt[PORT_P2] = 1'b1;
  end

endmodule

// File: rtl/sdram_arb.sv
// Slot-based SDRAM arbiter: one access per SLOT_LEN-clock slot, granted at the
// last phase. A slot with no grant leaves oe/we low so the controller refreshes.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int SLOT_LEN      = SLOT_LEN_DEF,
  parameter int CAPTURE_PHASE = CAPTURE_PHASE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] we,
  input  logic [24:0]      addr0,
  input  logic [24:0]      addr1,
  input  logic [24:0]      addr2,
  input  logic [7:0]       din0,
  input  logic [7:0]       din1,
  input  logic [7:0]       din2,
  output logic [NPORT-1:0] ack,
  output logic [NPORT-1:0] busy,
  output logic [7:0]       rdata,
  output logic             mem_clkref,
  output logic [1:0]       mem_bank,
  output logic [22:0]      mem_addr,
  output logic [7:0]       mem_din,
  output logic             mem_oe,
  output logic             mem_we,
  input  logic [7:0]       mem_dout
);

  localparam logic [3:0] LAST = 4'(SLOT_LEN - 1);
  localparam logic [3:0] CAP  = 4'(CAPTURE_PHASE);
  localparam logic [3:0] HALF = 4'(SLOT_LEN / 2);

  logic [3:0]       phase, phase_nxt;
  logic [NPORT-1:0] pending, inflight, accept, gnt;
  logic             rr, cur_we, grant_now;
  addr_t            addr_in [NPORT];
  logic [7:0]       din_in  [NPORT];
  addr_t            hold_addr [NPORT];
  logic [7:0]       hold_din  [NPORT];
  logic [NPORT-1:0] hold_we;

  assign addr_in[0] = addr0;
  assign addr_in[1] = addr1;
  assign addr_in[2] = addr2;
  assign din_in[0]  = din0;
  assign din_in[1]  = din1;
  assign din_in[2]  = din2;

  assign phase_nxt = (phase == LAST) ? 4'd0 : phase + 4'd1;
  assign busy      = pending | inflight;
  // Strobes from a busy port are dropped; inflight is already clear in the ack cycle
  assign accept    = req & ~busy;
  assign grant_now = (phase == LAST) && !init && (|pending);

  sdram_arb_prio u_prio (
    .pend (pending),
    .rr   (rr),
    .gnt  (gnt)
  );

  // Slot phase counter and the controller reference clock (high for the first half-slot)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 4'd0;
      mem_clkref <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      mem_clkref <= (phase_nxt < HALF);
    end
  end

  // Latch request parameters so requesters only need to present them with the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_we <= '0;
      for (int i = 0; i < NPORT; i++) begin
        hold_addr[i] <= '0;
        hold_din[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (accept[i]) begin
          hold_addr[i] <= addr_in[i];
          hold_din[i]  <= din_in[i];
          hold_we[i]   <= we[i];
        end
      end
    end
  end

  // Pending flags: set by an accepted strobe, cleared when that port wins a slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~(grant_now ? gnt : {NPORT{1'b0}})) | accept;
  end

  // Access sequencing: launch at slot start, capture/complete after CAPTURE_PHASE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_bank <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      cur_we   <= 1'b0;
      inflight <= '0;
      ack      <= '0;
      rr       <= 1'b0;
      rdata    <= 8'hFF;
    end else begin
      ack <= '0;
      if (grant_now) begin
        for (int i = 0; i < NPORT; i++) begin
          if (gnt[i]) begin
            mem_bank <= hold_addr[i][24:23];
            mem_addr <= hold_addr[i][22:0];
            mem_din  <= hold_din[i];
            mem_oe   <= !hold_we[i];
            mem_we   <= hold_we[i];
            cur_we   <= hold_we[i];
          end
        end
        inflight <= gnt;
        if (gnt[PORT_P1]) rr <= 1'b1;
        if (gnt[PORT_P2]) rr <= 1'b0;
      end else if (phase == CAP && (|inflight)) begin
        mem_oe   <= 1'b0;
        mem_we   <= 1'b0;
        ack      <= inflight;
        inflight <= '0;
        if (!cur_we) rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: directed vector table, corner sequences, and random traffic
// compared against a slot-level reference model.
module tb_sdram_arb;

  logic        clk = 1'b0, reset = 1'b1, init = 1'b0;
  logic [2:0]  req = '0, we = '0;
  logic [24:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [7:0]  din0 = '0, din1 = '0, din2 = '0, mem_dout = '0;
  logic [2:0]  ack, busy;
  logic [7:0]  rdata, mem_din;
  logic        mem_clkref, mem_oe, mem_we;
  logic [1:0]  mem_bank;
  logic [22:0] mem_addr;

  int checks = 0, failures = 0;
  int cyc;

  sdram_arb dut (
    .clk(clk), .reset(reset), .init(init), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .din0(din0), .din1(din1), .din2(din2),
    .ack(ack), .busy(busy), .rdata(rdata),
    .mem_clkref(mem_clkref), .mem_bank(mem_bank), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_oe(mem_oe), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; cyc % 16 is the expected slot phase
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; we = '0; init = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input int p, input logic w, input logic [24:0] a, input logic [7:0] d);
    case (p)
      0: begin addr0 = a; din0 = d; end
      1: begin addr1 = a; din1 = d; end
      default: begin addr2 = a; din2 = d; end
    endcase
    we[p]  = w;
    req[p] = 1'b1;
  endtask

  task automatic step_to(input int c);
    int n = 0;
    while (cyc != c && n < 200) begin @(negedge clk); n++; end
    chk("step_to", cyc, c);
  endtask

  // ---------------- reference model (slot level) ----------------
  logic [2:0]  m_pend, h_we;
  int          m_slot, m_last, m_t;
  logic        m_we;
  logic [24:0] m_addr, h_addr [3];
  logic [7:0]  m_din, m_rdata, h_din [3];

  function automatic logic m_busy(input int p);
    return m_pend[p] || (m_slot == p && (m_t % 16) <= 12);
  endfunction

  task automatic m_reset();
    m_pend = '0; h_we = '0; m_slot = -1; m_last = 2; m_t = 0;
    m_we = 1'b0; m_addr = '0; m_din = '0; m_rdata = 8'hFF;
    for (int p = 0; p < 3; p++) begin h_addr[p] = '0; h_din[p] = '0; end
  endtask

  task automatic m_check();
    int ph = m_t % 16;
    logic act = (m_slot >= 0) && (ph <= 12);
    logic [2:0] eb, ea;
    for (int p = 0; p < 3; p++) eb[p] = m_busy(p);
    ea = (m_slot >= 0 && ph == 13) ? (3'b001 << m_slot) : 3'b000;
    chk("r_oe", mem_oe, act && !m_we);
    chk("r_we", mem_we, act && m_we);
    chk("r_ack", ack, ea);
    chk("r_busy", busy, eb);
    chk("r_rdata", rdata, m_rdata);
    chk("r_clkref", mem_clkref, (m_t > 0) && (ph < 8));
    chk("r_bankaddr", {mem_bank, mem_addr}, m_addr);
    chk("r_din", mem_din, m_din);
  endtask

  task automatic m_step();
    int ph = m_t % 16;
    int w = -1;
    logic [2:0] b;
    for (int p = 0; p < 3; p++) b[p] = m_busy(p);
    if (ph == 12 && m_slot >= 0 && !m_we) m_rdata = mem_dout;
    if (ph == 15) begin
      m_slot = -1;
      if (!init) begin
        if (m_pend[0])                  w = 0;
        else if (m_pend[1] && m_pend[2]) w = (m_last == 1) ? 2 : 1;
        else if (m_pend[1])             w = 1;
        else if (m_pend[2])             w = 2;
      end
      if (w >= 0) begin
        m_pend[w] = 1'b0; m_slot = w;
        m_we = h_we[w]; m_addr = h_addr[w]; m_din = h_din[w];
        if (w > 0) m_last = w;
      end
    end
    for (int p = 0; p < 3; p++) begin
      if (req[p] && !b[p]) begin
        m_pend[p] = 1'b1;
        h_we[p]   = we[p];
        h_addr[p] = (p == 0) ? addr0 : (p == 1) ? addr1 : addr2;
        h_din[p]  = (p == 0) ? din0  : (p == 1) ? din1  : din2;
      end
    end
    m_t++;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          port;
    logic        w;
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  mdout;
    logic [1:0]  e_bank;
    logic [22:0] e_addr;
    logic [7:0]  e_din;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [2:0] ea;
    vt[0] = '{1, 1'b0, 25'h0000123, 8'h00, 8'h5A, 2'b00, 23'h000123, 8'h00, 8'h5A};
    vt[1] = '{0, 1'b1, 25'h1000001, 8'hC3, 8'h77, 2'b10, 23'h000001, 8'hC3, 8'hFF};
    vt[2] = '{2, 1'b0, 25'h1FFFFFF, 8'h11, 8'h3C, 2'b11, 23'h7FFFFF, 8'h11, 8'h3C};
    vt[3] = '{2, 1'b1, 25'h0800000, 8'h9E, 8'h01, 2'b01, 23'h000000, 8'h9E, 8'hFF};

    // Reset state while reset is held
    reset = 1'b1;
    @(negedge clk);
    chk("rst_oe", mem_oe, 0);   chk("rst_we", mem_we, 0);
    chk("rst_ack", ack, 0);     chk("rst_busy", busy, 0);
    chk("rst_clkref", mem_clkref, 0);
    chk("rst_rdata", rdata, 8'hFF);
    chk("rst_addr", {mem_bank, mem_addr, mem_din}, 0);

    // Single accesses from the table
    foreach (vt[i]) begin
      do_reset();
      mem_dout = vt[i].mdout;
      strobe(vt[i].port, vt[i].w, vt[i].a, vt[i].d);
      @(negedge clk);
      req = '0;
      chk("v_busy_pend", busy[vt[i].port], 1);
      step_to(16);
      for (int k = 0; k < 16; k++) begin
        chk("v_oe", mem_oe, !vt[i].w && k <= 12);
        chk("v_we", mem_we, vt[i].w && k <= 12);
        chk("v_ack", ack, (k == 13) ? (3'b001 << vt[i].port) : 3'b000);
        if (k == 0) begin
          chk("v_bank", mem_bank, vt[i].e_bank);
          chk("v_addr", mem_addr, vt[i].e_addr);
          chk("v_din", mem_din, vt[i].e_din);
        end
        if (k == 5)  chk("v_busy_fly", busy[vt[i].port], 1);
        if (k == 13) begin
          chk("v_rdata", rdata, vt[i].e_rdata);
          chk("v_busy_ack", busy[vt[i].port], 0);
        end
        @(negedge clk);
      end
    end

    // All three strobe together: served 0,1,2 in consecutive slots
    do_reset();
    req = 3'b111; we = 3'b000;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      req = '0;
      ea = (c == 29) ? 3'b001 : (c == 45) ? 3'b010 : (c == 61) ? 3'b100 : 3'b000;
      chk("all3_ack", ack, ea);
    end

    // Ports 1 and 2 requesting continuously alternate
    do_reset();
    req = 3'b110; we = 3'b000;
    for (int c = 1; c <= 112; c++) begin
      @(negedge clk);
      ea = 3'b000;
      if (c >= 29 && (c - 29) % 16 == 0 && (c - 29) / 16 < 6)
        ea = (((c - 29) / 16) % 2 == 0) ? 3'b010 : 3'b100;
      chk("rr_ack", ack, ea);
    end
    req = '0;

    // init held for three slots with port 2 pending
    do_reset();
    init = 1'b1;
    strobe(2, 1'b0, 25'h0000456, 8'h00);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      req = '0;
      chk("init_oe", mem_oe, c >= 64 && c <= 76);
      chk("init_ack", ack, (c == 77) ? 3'b100 : 3'b000);
      if (c == 48) init = 1'b0;
    end

    // Reset in the middle of a read aborts it
    do_reset();
    strobe(1, 1'b0, 25'h0000789, 8'h00);
    @(negedge clk);
    req = '0;
    step_to(21);
    chk("abort_pre_oe", mem_oe, 1);
    reset = 1'b1;
    #1;
    chk("abort_oe", mem_oe, 0);     chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);     chk("abort_clkref", mem_clkref, 0);
    chk("abort_rdata", rdata, 8'hFF);
    chk("abort_addr", {mem_bank, mem_addr, mem_din}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk("abort_no_ack", ack, 0);
      chk("abort_no_oe", mem_oe, 0);
      if (c == 7) chk("abort_clk7", mem_clkref, 1);
      if (c == 8) chk("abort_clk8", mem_clkref, 0);
    end

    // Random traffic against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 1500; i++) begin
      m_check();
      for (int p = 0; p < 3; p++) req[p] = ($urandom_range(0, 5) == 0);
      we       = 3'($urandom());
      addr0    = 25'($urandom()); addr1 = 25'($urandom()); addr2 = 25'($urandom());
      din0     = 8'($urandom());  din1  = 8'($urandom());  din2  = 8'($urandom());
      mem_dout = 8'($urandom());
      init     = ((i / 120) % 4 == 3);
      m_step();
      @(negedge clk);
    end
    m_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
